elevator_scheduler: RTL and testbench

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 147 ++++++++++++++
 tb/tb_elevator_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: latches floor calls, keeps travelling in one
// direction while calls lie ahead, and only reverses while idle.
module elevator_scheduler #(
  parameter int FLOORS      = 8,
  parameter int MOVE_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       call_req,
  input  logic [3:0] call_floor,
  output logic [2:0] cur_floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open,
  output logic       arrive,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  localparam logic [3:0]  FLOORS_W  = 4'(FLOORS);
  localparam logic [31:0] MOVE_LOAD = 32'(MOVE_CYCLES - 1);
  localparam logic [31:0] DOOR_LOAD = 32'(DOOR_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_cur;
  logic        r_dir;
  logic        r_moving;
  logic        r_door;
  logic        r_arrive;
  logic [7:0]  r_pending;
  logic [31:0] r_timer;

  logic       w_valid;
  logic [7:0] w_set;
  logic [7:0] w_cur_mask;
  logic [2:0] w_next;
  logic [7:0] w_next_mask;
  logic       w_above;
  logic       w_below;
  logic       w_hit_next;
  logic       w_cur_call;

  always_comb begin
    w_valid     = call_req && (call_floor < FLOORS_W);
    w_set       = w_valid ? (8'd1 << call_floor) : '0;
    w_cur_mask  = 8'd1 << r_cur;
    w_next      = r_dir ? (r_cur + 3'd1) : (r_cur - 3'd1);
    w_next_mask = 8'd1 << w_next;
    w_hit_next  = r_pending[w_next] || (w_valid && (call_floor == {1'b0, w_next}));
    w_cur_call  = w_valid && (call_floor == {1'b0, r_cur});
    w_above     = 1'b0;
    w_below     = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r_pending[i] && (i > 32'(r_cur))) w_above = 1'b1;
      if (r_pending[i] && (i < 32'(r_cur))) w_below = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cur     <= '0;
      r_dir     <= 1'b1;
      r_moving  <= 1'b0;
      r_door    <= 1'b0;
      r_arrive  <= 1'b0;
      r_pending <= '0;
      r_timer   <= '0;
    end else begin
      r_arrive <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pending == '0) begin
            r_pending <= w_set;
          end else if (r_pending[r_cur]) begin
            r_state   <= DOOR;
            r_door    <= 1'b1;
            r_timer   <= DOOR_LOAD;
            r_pending <= (r_pending | w_set) & ~w_cur_mask;
          end else begin
            // Reverse only when nothing is pending in the current direction.
            if (r_dir ? !w_above : !w_below) r_dir <= ~r_dir;
            r_state   <= MOVE;
            r_moving  <= 1'b1;
            r_timer   <= MOVE_LOAD;
            r_pending <= r_pending | w_set;
          end
        end
        MOVE: begin
          if (r_timer != '0) begin
            r_timer   <= r_timer - 32'd1;
            r_pending <= r_pending | w_set;
          end else begin
            r_cur    <= w_next;
            r_arrive <= 1'b1;
            if (w_hit_next) begin
              r_state   <= DOOR;
              r_moving  <= 1'b0;
              r_door    <= 1'b1;
              r_timer   <= DOOR_LOAD;
              r_pending <= (r_pending | w_set) & ~w_next_mask;
            end else begin
              r_timer   <= MOVE_LOAD;
              r_pending <= r_pending | w_set;
            end
          end
        end
        DOOR: begin
          if (w_cur_call) begin
            r_timer <= DOOR_LOAD;
          end else begin
            r_pending <= r_pending | w_set;
            if (r_timer == '0) begin
              r_state <= IDLE;
              r_door  <= 1'b0;
            end else begin
              r_timer <= r_timer - 32'd1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_moving <= 1'b0;
          r_door   <= 1'b0;
        end
      endcase
    end
  end

  // A pending call always lies ahead while moving, so the shaft ends are never overrun.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == MOVE) && (r_timer == '0)) begin
      assert (!((r_cur == 3'd0) && !r_dir) && !((r_cur == 3'(FLOORS - 1)) && r_dir))
        else $error("elevator_scheduler: travel beyond shaft end");
    end
  end

  assign cur_floor = r_cur;
  assign dir_up    = r_dir;
  assign moving    = r_moving;
  assign door_open = r_door;
  assign arrive    = r_arrive;
  assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with short move/door timings.
module tb_elevator_scheduler;

  logic       clk;
  logic       rst_n;
  logic       call_req;
  logic [3:0] call_floor;
  logic [2:0] cur_floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic       arrive;
  logic [7:0] pending;

  int checks   = 0;
  int failures = 0;

  elevator_scheduler #(
    .FLOORS      (8),
    .MOVE_CYCLES (4),
    .DOOR_CYCLES (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .call_req   (call_req),
    .call_floor (call_floor),
    .cur_floor  (cur_floor),
    .dir_up     (dir_up),
    .moving     (moving),
    .door_open  (door_open),
    .arrive     (arrive),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic call(input logic [3:0] f);
    call_req   = 1'b1;
    call_floor = f;
    @(posedge clk);
    #1;
    call_req   = 1'b0;
    call_floor = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cur"},  32'(cur_floor), 0);
    chk({tag, "_dir"},  32'(dir_up),    1);
    chk({tag, "_mov"},  32'(moving),    0);
    chk({tag, "_door"}, 32'(door_open), 0);
    chk({tag, "_arr"},  32'(arrive),    0);
    chk({tag, "_pend"}, 32'(pending),   0);
  endtask

  initial begin
    rst_n      = 1'b0;
    call_req   = 1'b0;
    call_floor = '0;
    tick(2);
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Call at floor 0: latched on edge 1, door opens on edge 2 for 6 cycles.
    call(4'd0);
    chk("c0_pend_latched", 32'(pending), 32'h01);
    chk("c0_door_early",   32'(door_open), 0);
    tick(1);
    chk("c0_door_open",    32'(door_open), 1);
    chk("c0_pend_clear",   32'(pending), 0);
    tick(5);
    chk("c0_door_last",    32'(door_open), 1);
    tick(1);
    chk("c0_door_closed",  32'(door_open), 0);
    chk("c0_idle_mov",     32'(moving), 0);

    // Call floor 3: arrivals at 1, 2, 3 every 4 cycles.
    call(4'd3);
    chk("c3_pend",  32'(pending), 32'h08);
    chk("c3_mov0",  32'(moving), 0);
    tick(1);
    chk("c3_moving", 32'(moving), 1);
    tick(3);
    chk("c3_cur0",  32'(cur_floor), 0);
    chk("c3_arr0",  32'(arrive), 0);
    tick(1);
    chk("c3_cur1",  32'(cur_floor), 1);
    chk("c3_arr1",  32'(arrive), 1);
    tick(1);
    chk("c3_arr1_end", 32'(arrive), 0);
    tick(3);
    chk("c3_cur2",  32'(cur_floor), 2);
    chk("c3_arr2",  32'(arrive), 1);
    tick(4);
    chk("c3_cur3",  32'(cur_floor), 3);
    chk("c3_arr3",  32'(arrive), 1);
    chk("c3_door",  32'(door_open), 1);
    chk("c3_stop",  32'(moving), 0);
    chk("c3_pclr",  32'(pending), 0);

    // At floor 3 going up: calls 5 and 1 while door open.
    call(4'd5);
    call(4'd1);
    chk("c51_pend", 32'(pending), 32'h22);
    chk("c51_door", 32'(door_open), 1);
    tick(4);
    chk("c51_idle_door", 32'(door_open), 0);
    chk("c51_idle_mov",  32'(moving), 0);
    tick(1);
    chk("c51_mov_up", 32'(moving), 1);
    chk("c51_dir_up", 32'(dir_up), 1);
    tick(4);
    chk("c51_cur4",   32'(cur_floor), 4);
    chk("c51_arr4",   32'(arrive), 1);
    tick(4);
    chk("c51_cur5",   32'(cur_floor), 5);
    chk("c51_door5",  32'(door_open), 1);
    chk("c51_pend1",  32'(pending), 32'h02);

    // Door at 5: repeat call at timer=2 restarts the door for 6 more cycles.
    tick(3);
    call(4'd5);
    chk("d5_door",    32'(door_open), 1);
    chk("d5_pend",    32'(pending), 32'h02);
    tick(5);
    chk("d5_still_open", 32'(door_open), 1);
    tick(1);
    chk("d5_closed",  32'(door_open), 0);
    tick(1);
    chk("rev_mov",    32'(moving), 1);
    chk("rev_dir",    32'(dir_up), 0);
    tick(16);
    chk("rev_cur1",   32'(cur_floor), 1);
    chk("rev_door1",  32'(door_open), 1);
    chk("rev_arr1",   32'(arrive), 1);
    chk("rev_pend",   32'(pending), 0);
    chk("rev_dir_hold", 32'(dir_up), 0);
    tick(6);
    chk("rev_idle",   32'(door_open), 0);

    // Out-of-range floors are ignored.
    call(4'd9);
    chk("oor9_pend",  32'(pending), 0);
    call(4'd15);
    chk("oor15_pend", 32'(pending), 0);
    tick(1);
    chk("oor_mov",    32'(moving), 0);
    chk("oor_door",   32'(door_open), 0);

    // Reset mid-MOVE between floors 2 and 3 with extra call pending.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    call(4'd3);
    tick(10);
    chk("mr_cur2",  32'(cur_floor), 2);
    call(4'd6);
    tick(1);
    chk("mr_pend",  32'(pending), 32'h48);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mr_async");
    @(posedge clk);
    #1;
    chk_reset_vals("mr_held");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    chk_reset_vals("mr_after");

    // Top floor: travel 0 -> 7.
    call(4'd7);
    tick(29);
    chk("top_cur7",  32'(cur_floor), 7);
    chk("top_door",  32'(door_open), 1);
    chk("top_pend",  32'(pending), 0);
    tick(7);
    chk("top_idle_mov",  32'(moving), 0);
    chk("top_idle_door", 32'(door_open), 0);
    chk("top_dir",       32'(dir_up), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
